// File: rtl/mm_line_seq.sv
// Line-transfer sequencer: expands a FILL / WB / EVICT line command into a run of
// 32-bit word accesses to main memory, with a no-ack watchdog per word.
module mm_line_seq #(
  parameter int LA_W  = 27,
  parameter int WORDS = 8,
  parameter int TMO   = 255
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [1:0]                      req_op,
  input  logic [LA_W-1:0]                 req_fill_la,
  input  logic [LA_W-1:0]                 req_wb_la,
  input  logic [32*WORDS-1:0]             req_wdata,
  output logic                            mm_req,
  output logic                            mm_we,
  output logic [LA_W+$clog2(WORDS)-1:0]   mm_addr,
  output logic [31:0]                     mm_wdata,
  input  logic                            mm_ack,
  input  logic [31:0]                     mm_rdata,
  output logic                            done,
  output logic                            err,
  output logic [32*WORDS-1:0]             fill_data,
  output logic                            busy,
  output logic [1:0]                      state_dbg
);
  localparam int IW = $clog2(WORDS);
  localparam int LW = 32 * WORDS;
  localparam logic [9:0]    TMO_LAST = 10'(TMO - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state, state_d;
  logic [1:0]      op_q;
  logic [LA_W-1:0] fill_la_q, wb_la_q;
  logic [LW-1:0]   wdata_q;
  logic [IW-1:0]   idx;
  logic [9:0]      wd_cnt;
  logic            err_q;
  logic            accept, word_ack, last_word, timeout;

  // Handshakes: req_valid/req_ready is a strict valid/ready pair (transfer when both
  // are high on a rising edge); mm_req/mm_ack completes a word when both are high,
  // and mm_ack is ignored whenever mm_req is low.
  always_comb begin
    state_d   = state;
    req_ready = (state == IDLE);
    mm_req    = (state == WB) || (state == FILL);
    mm_we     = (state == WB);
    mm_addr   = '0;
    mm_wdata  = '0;
    accept    = req_ready && req_valid;
    word_ack  = mm_req && mm_ack;
    last_word = (idx == IDX_LAST);
    timeout   = mm_req && !mm_ack && (wd_cnt == TMO_LAST);

    if (state == WB) begin
      mm_addr  = {wb_la_q, idx};
      mm_wdata = wdata_q[32*int'(idx) +: 32];
    end else if (state == FILL) begin
      mm_addr = {fill_la_q, idx};
    end

    case (state)
      IDLE: begin
        if (accept) begin
          case (req_op)
            2'b00:   state_d = DONE;
            2'b01:   state_d = FILL;
            default: state_d = WB;
          endcase
        end
      end
      WB: begin
        if (word_ack && last_word) state_d = (op_q == 2'b11) ? FILL : DONE;
        else if (timeout)          state_d = DONE;
      end
      FILL: begin
        if ((word_ack && last_word) || timeout) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign done      = (state == DONE);
  assign err       = (state == DONE) && err_q;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= '0;
      fill_la_q <= '0;
      wb_la_q   <= '0;
      wdata_q   <= '0;
      idx       <= '0;
      wd_cnt    <= '0;
      err_q     <= 1'b0;
      fill_data <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        op_q      <= req_op;
        fill_la_q <= req_fill_la;
        wb_la_q   <= req_wb_la;
        wdata_q   <= req_wdata;
        idx       <= '0;
        wd_cnt    <= '0;
        err_q     <= (req_op == 2'b00);
        // Only commands that will read a line start from a clean buffer.
        if (req_op[0]) fill_data <= '0;
      end else if (word_ack) begin
        wd_cnt <= '0;
        idx    <= last_word ? '0 : idx + 1'b1;
        if (state == FILL) fill_data[32*int'(idx) +: 32] <= mm_rdata;
      end else if (mm_req) begin
        wd_cnt <= wd_cnt + 1'b1;
        if (timeout) err_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mm_line_seq.sv
// Directed bench for mm_line_seq: a table of line commands with hand-computed
// completion cycles, plus a hand-written asynchronous-reset-mid-fill sequence.
module tb_mm_line_seq;
  localparam int LA_W  = 27;
  localparam int WORDS = 8;
  localparam int LW    = 32 * WORDS;
  localparam int AW    = LA_W + 3;
  localparam int TMO   = 4;

  logic            clk, rst_n;
  logic            req_valid, req_ready;
  logic [1:0]      req_op;
  logic [LA_W-1:0] req_fill_la, req_wb_la;
  logic [LW-1:0]   req_wdata;
  logic            mm_req, mm_we, mm_ack;
  logic [AW-1:0]   mm_addr;
  logic [31:0]     mm_wdata, mm_rdata;
  logic            done, err, busy;
  logic [LW-1:0]   fill_data;
  logic [1:0]      state_dbg;

  mm_line_seq #(.LA_W(LA_W), .WORDS(WORDS), .TMO(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_fill_la(req_fill_la), .req_wb_la(req_wb_la),
    .req_wdata(req_wdata), .mm_req(mm_req), .mm_we(mm_we), .mm_addr(mm_addr),
    .mm_wdata(mm_wdata), .mm_ack(mm_ack), .mm_rdata(mm_rdata), .done(done),
    .err(err), .fill_data(fill_data), .busy(busy), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]      op;
    logic [LA_W-1:0] fla;
    logic [LA_W-1:0] wla;
    int              ack_div;     // ack on every ack_div-th cycle of mm_req
    int              stop_after;  // stop acking after this many acks
    int              exp_done;    // cycle of the done pulse, accept = cycle 0
    logic            exp_err;
    int              exp_acks;
  } vec_t;

  vec_t              vecs[9];
  logic [AW+32:0]    exp_q[$];
  logic [LW-1:0]     exp_fill;
  int                checks = 0;
  int                errors = 0;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] wb_word(input logic [LA_W-1:0] la, input int i);
    if (la == 27'h3) return 32'h1111_1111 * i;
    return {la[7:0], 16'hD00D, 8'(i)};
  endfunction

  // driver + scoreboard for one table entry
  task automatic run_vec(input vec_t v, input int n);
    logic [LW-1:0]  wd;
    logic [AW+32:0] cur_bus, prev_bus, exp_bus;
    logic           prev_req, prev_ack, ack, exp_req, exp_busy, err_at_done;
    int             cyc, req_cycles, acks, done_cyc, done_cnt, fill_acks;
    int             bad_req, bad_busy, bad_err, bad_stable;

    for (int i = 0; i < WORDS; i++) wd[32*i +: 32] = wb_word(v.wla, i);
    exp_q.delete();
    if (v.op[1]) for (int i = 0; i < WORDS; i++) exp_q.push_back({1'b1, v.wla, 3'(i), wd[32*i +: 32]});
    if (v.op[0]) for (int i = 0; i < WORDS; i++) exp_q.push_back({1'b0, v.fla, 3'(i), 32'h0});
    if (v.op[0]) begin
      exp_fill  = '0;
      fill_acks = v.exp_acks - ((v.op == 2'b11) ? WORDS : 0);
      for (int i = 0; i < fill_acks; i++) exp_fill[32*i +: 32] = 32'hA0 + i;
    end

    req_valid   = 1'b1;
    req_op      = v.op;
    req_fill_la = v.fla;
    req_wb_la   = v.wla;
    req_wdata   = wd;
    cyc = 0; req_cycles = 0; acks = 0; done_cyc = -1; done_cnt = 0;
    bad_req = 0; bad_busy = 0; bad_err = 0; bad_stable = 0;
    prev_req = 1'b0; prev_ack = 1'b0; prev_bus = '0; err_at_done = 1'b0;

    while (cyc < v.exp_done + 3) begin
      exp_req  = (v.op != 2'b00) && (cyc >= 1) && (cyc < v.exp_done);
      exp_busy = (cyc >= 1) && (cyc <= v.exp_done);
      if (mm_req !== exp_req) bad_req++;
      if (busy !== exp_busy || req_ready !== !exp_busy) bad_busy++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
        err_at_done = err;
      end else if (err !== 1'b0) bad_err++;
      cur_bus = {mm_we, mm_addr, mm_wdata};
      if (mm_req && prev_req && !prev_ack && cur_bus !== prev_bus) bad_stable++;

      // stray acks whenever mm_req is low must be ignored
      ack = 1'b1;
      if (mm_req) begin
        req_cycles++;
        ack = (acks < v.stop_after) && (req_cycles % v.ack_div == 0);
      end
      mm_ack   = ack;
      mm_rdata = (mm_req && ack) ? 32'hA0 + 32'(mm_addr[2:0]) : 32'hDEAD_BEEF;
      if (mm_req && ack) begin
        acks++;
        if (exp_q.size() > 0) begin
          exp_bus = exp_q.pop_front();
          chk($sformatf("v%0d_access%0d", n, acks), cur_bus, exp_bus);
        end
      end
      prev_req = mm_req;
      prev_ack = mm_req && ack;
      prev_bus = cur_bus;
      @(posedge clk); #1;
      req_valid = 1'b0;
      cyc++;
    end
    mm_ack = 1'b0;

    chk($sformatf("v%0d_done_count", n), done_cnt, 1);
    chk($sformatf("v%0d_done_cycle", n), done_cyc, v.exp_done);
    chk($sformatf("v%0d_err", n), err_at_done, v.exp_err);
    chk($sformatf("v%0d_ack_count", n), acks, v.exp_acks);
    chk($sformatf("v%0d_mm_req_window", n), bad_req, 0);
    chk($sformatf("v%0d_busy_ready", n), bad_busy, 0);
    chk($sformatf("v%0d_err_outside_done", n), bad_err, 0);
    chk($sformatf("v%0d_bus_stable", n), bad_stable, 0);
    chk($sformatf("v%0d_fill_data", n), fill_data, exp_fill);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    int bad;
    vecs[0] = '{2'b10, 27'h0000000, 27'h0000003, 3, 99, 25, 1'b0, 8};  // WB, ack every 3rd
    vecs[1] = '{2'b01, 27'h0000010, 27'h0000000, 1, 99,  9, 1'b0, 8};  // FILL back-to-back
    vecs[2] = '{2'b11, 27'h0000009, 27'h0000005, 1, 99, 17, 1'b0, 16}; // EVICT back-to-back
    vecs[3] = '{2'b00, 27'h0000011, 27'h0000012, 1, 99,  1, 1'b1, 0};  // illegal op
    vecs[4] = '{2'b01, 27'h0000002, 27'h0000000, 1,  3,  8, 1'b1, 3};  // timeout at word 3
    vecs[5] = '{2'b01, 27'h0000007, 27'h0000000, 4, 99, 33, 1'b0, 8};  // ack in timeout cycle
    vecs[6] = '{2'b11, 27'h0000008, 27'h0000006, 5, 99,  5, 1'b1, 0};  // EVICT times out in WB
    vecs[7] = '{2'b10, 27'h0000000, 27'h7FFFFFF, 2, 99, 17, 1'b0, 8};  // top line address
    vecs[8] = '{2'b01, 27'h0000004, 27'h0000000, 1, 99,  9, 1'b0, 8};  // after mid-fill reset

    rst_n = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_fill_la = '0; req_wb_la = '0;
    req_wdata = '0; mm_ack = 1'b0; mm_rdata = '0; exp_fill = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_mm_req", mm_req, 0);
    chk("rst_mm_we", mm_we, 0);
    chk("rst_mm_addr", mm_addr, 0);
    chk("rst_mm_wdata", mm_wdata, 0);
    chk("rst_done_err", {done, err}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fill_data", fill_data, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // ack while idle is ignored
    bad = 0;
    mm_ack = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (busy !== 1'b0 || done !== 1'b0 || mm_req !== 1'b0) bad++;
    end
    mm_ack = 1'b0;
    chk("idle_ack_ignored", bad, 0);

    for (int n = 0; n < 8; n++) run_vec(vecs[n], n);

    // asynchronous reset while FILL is on word 4
    req_valid = 1'b1; req_op = 2'b01; req_fill_la = 27'h0000020;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mm_ack = mm_req;
      mm_rdata = 32'hA0 + 32'(mm_addr[2:0]);
      @(posedge clk); #1;
    end
    mm_ack = 1'b0;
    chk("rst_mid_word4_addr", mm_addr, {27'h0000020, 3'd4});
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_mm_req", mm_req, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_fill_data", fill_data, 0);
    bad = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (done !== 1'b0) bad++;
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    if (done !== 1'b0) bad++;
    chk("rst_mid_no_done", bad, 0);
    chk("rst_mid_req_ready", req_ready, 1);
    exp_fill = '0;
    run_vec(vecs[8], 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
